id_issue_ctrl: RTL

//  Issue controller between the decode stage and EX. Holds a register scoreboard of pending writes.

---
 rtl/core_pkg.sv | 36 +++
 rtl/id_issue_ctrl_if.sv | 66 ++++++
 rtl/reg_scoreboard.sv | 56 +++++
 rtl/id_issue_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
//============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the decode-to-EX issue
//               controller: state encoding, issue slot layout, GPR geometry.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package core_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
    localparam int CTRL_W     = 4;
    localparam int CNT_W      = 16;
    localparam int ZERO_REG   = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic [CTRL_W-1:0]     alu_control;
    } issue_slot_t;

    // One-hot register select used by every scoreboard set/clear path
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_issue_ctrl_if.sv
//============================================================================
// Module      : id_issue_ctrl_if
// Description : Decode / EX / writeback bundle of the issue controller.
//               ISSUE_PERF_CNT_EN adds the stall_cycles / issue_count
//               counter outputs.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface id_issue_ctrl_if
    import core_pkg::*;
`ifdef ISSUE_PERF_CNT_EN
#(
    parameter int CNT_W = core_pkg::CNT_W
)
`endif
;
    logic                  flush;
    logic                  id_valid;
    logic                  id_ready;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic [CTRL_W-1:0]     id_alu_control;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic [CTRL_W-1:0]     ex_alu_control;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [NUM_REGS-1:0]   pending_mask;
    logic                  busy;
`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      issue_count;
`endif

    // Pipeline side: decode, EX and writeback drive the controller
    modport master (
        output flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_alu_control, ex_ready, wb_valid, wb_addr,
        input  id_ready, ex_valid, ex_rd, ex_reg_write, ex_alu_control,
               pending_mask, busy
`ifdef ISSUE_PERF_CNT_EN
             , stall_cycles, issue_count
`endif
    );

    // Controller side
    modport slave (
        input  flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_alu_control, ex_ready, wb_valid, wb_addr,
        output id_ready, ex_valid, ex_rd, ex_reg_write, ex_alu_control,
               pending_mask, busy
`ifdef ISSUE_PERF_CNT_EN
             , stall_cycles, issue_count
`endif
    );

endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
//============================================================================
// Module      : reg_scoreboard
// Description : Pending-write bit per GPR. Set on issue, cleared on
//               writeback or when the issue slot holding the write is
//               squashed. Also exports the hazard-check view of the mask
//               with same-cycle writebacks already removed.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module reg_scoreboard
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic                  set_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  squash_i,
    input  logic [REG_ADDR_W-1:0] squash_addr_i,
    output logic [NUM_REGS-1:0]   pending_o,
    output logic [NUM_REGS-1:0]   eff_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] sq_clr;
    logic [NUM_REGS-1:0] set_m;

    // Clears applied before the set so a same-cycle issue to the register
    // being written back stays pending; r0 can never become pending.
    always_comb begin
        wb_clr    = wb_valid_i ? reg_onehot(wb_addr_i)     : '0;
        sq_clr    = squash_i   ? reg_onehot(squash_addr_i) : '0;
        set_m     = set_i      ? reg_onehot(set_addr_i)    : '0;
        pending_d = ((pending_q & ~wb_clr & ~sq_clr) | set_m)
                    & ~reg_onehot(REG_ADDR_W'(ZERO_REG));
        eff_o     = pending_q & ~wb_clr;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

`default_nettype wire

// File: rtl/id_issue_ctrl.sv
//============================================================================
// Module      : id_issue_ctrl
// Description : Decode-to-EX issue controller. Stalls decode on RAW/WAW
//               hazards against the pending-write scoreboard and on EX
//               back-pressure, squashes the EX slot on flush, and drives a
//               registered one-entry issue slot toward EX.
//               Optional feature macro: ISSUE_PERF_CNT_EN (saturating
//               stall-cycle and issue counters).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module id_issue_ctrl
    import core_pkg::*;
`ifdef ISSUE_PERF_CNT_EN
#(
    parameter int CNT_W = core_pkg::CNT_W
)
`endif
(
    input  logic           clk,
    input  logic           rst,
    id_issue_ctrl_if.slave bus
);

    issue_state_e        state_q, state_d;
    issue_slot_t         slot_q, slot_d;
    logic                ex_valid_q, ex_valid_d;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] eff_mask;
    logic                hazard;
    logic                slot_free;
    logic                stall_cond;
    logic                id_ready;
    logic                fire;

    reg_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .wb_valid_i    (bus.wb_valid),
        .wb_addr_i     (bus.wb_addr),
        .set_i         (fire & bus.id_reg_write & (bus.id_rd != REG_ADDR_W'(ZERO_REG))),
        .set_addr_i    (bus.id_rd),
        .squash_i      (bus.flush & ex_valid_q & slot_q.reg_write),
        .squash_addr_i (slot_q.rd),
        .pending_o     (pending),
        .eff_o         (eff_mask)
    );

    // Hazard/handshake decode. STALL only records that decode is waiting:
    // the stall conditions themselves hold id_ready low, so the cycle that
    // clears them (writeback, ex_ready) issues immediately. FLUSH is the
    // one-bubble refetch window and always blocks.
    always_comb begin
        hazard     = bus.id_valid &
                     ((bus.id_uses_rs   & eff_mask[bus.id_rs]) |
                      (bus.id_uses_rt   & eff_mask[bus.id_rt]) |
                      (bus.id_reg_write & eff_mask[bus.id_rd]));
        slot_free  = ~ex_valid_q | bus.ex_ready;
        stall_cond = bus.id_valid & (hazard | ~slot_free);
        id_ready   = ~rst & (state_q != FLUSH) & slot_free & ~hazard & ~bus.flush;
        fire       = bus.id_valid & id_ready;
    end

    // Next state: flush from any state, FLUSH lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                RUN:     if (stall_cond)  state_d = STALL;
                STALL:   if (!stall_cond) state_d = RUN;
                FLUSH:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Issue slot next value: flush squashes, fire loads, consume empties
    always_comb begin
        slot_d     = slot_q;
        ex_valid_d = ex_valid_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
            slot_d     = '0;
        end else if (fire) begin
            ex_valid_d         = 1'b1;
            slot_d.rd          = bus.id_rd;
            slot_d.reg_write   = bus.id_reg_write;
            slot_d.alu_control = bus.id_alu_control;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
            slot_d     = '0;
        end
    end

    // State and slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            slot_q     <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign bus.id_ready       = id_ready;
    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_rd          = slot_q.rd;
    assign bus.ex_reg_write   = slot_q.reg_write;
    assign bus.ex_alu_control = slot_q.alu_control;
    assign bus.pending_mask   = pending;
    assign bus.busy           = (|pending) | ex_valid_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] issue_cnt_q;

    // Saturating counters: cycles spent in STALL and instructions issued
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            if ((state_q == STALL) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (fire && (issue_cnt_q != '1)) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.issue_count  = issue_cnt_q;
`endif

endmodule

`default_nettype wire
